seg_page_sched: RTL and testbench
=================================

Name: seg_page_sched

Overview:
Display scheduler that time-shares one SEG_UNITS-digit raw 7-segment display between NUM_PAGES producer pages and one priority alert source.
- Rotates round-robin through valid pages with a programmable dwell and a blank gap between pages.
- Pre-empts rotation for alerts.
- Its word output feeds the raw segment-pattern input of the display multiplexer.

Parameters:
- SEG_UNITS, 4, digits on the display; each word is SEG_UNITS*8 bits (DP in bit 7 of each byte).
- NUM_PAGES, 4, number of page requesters; 1..8.
- DWELL_CYCLES, 50000000, clk cycles a page is shown; >=1, fits in 32 bits.
- BLANK_CYCLES, 5000000, clk cycles of all-zero word between pages; >=1.
- ALERT_CYCLES, 100000000, clk cycles an alert is shown; >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- page_word  in  NUM_PAGES*SEG_UNITS*8  page p occupies bits [p*W+W-1 : p*W], where W = SEG_UNITS*8.
- page_valid  in  NUM_PAGES  page p has content to show.
- next_page  in  1  single-cycle pulse; skip to the next page now.
- hold  in  1  level; freezes the dwell counter.
- alert_req  in  1  single-cycle pulse; show alert_word.
- alert_word  in  SEG_UNITS*8  alert content; sampled on an accepted alert_req.
- alert_ack  out  1  one-cycle pulse, asserted the cycle after alert_req is accepted.
- word  out  SEG_UNITS*8  registered raw segment word to the display.
- cur_page  out  3  index of the page currently selected.
- page_switch  out  1  one-cycle pulse when a new page enters SHOW.

Behaviour:
Clocking and reset
- Single clock. All state and outputs are registered.
- Reset (async, active-high) sets: state=IDLE, word=0, cur_page=0, alert_ack=0, page_switch=0, dwell/blank/alert counters=0, latched alert word=0.

States: IDLE, SHOW, BLANK, ALERT.

Page search
- pick(start, inclusive) returns the first p with page_valid[p] set, scanning start, start+1, ... modulo NUM_PAGES.
- Inclusive mode tests start first; exclusive mode tests start last.
- Result is a found flag plus an index.

IDLE
- word=0.
- If any page_valid is set: cur_page <= pick(0, inclusive), state <= SHOW, page_switch pulses.

SHOW
- word <= slice cur_page of page_word every cycle (live, 1-cycle latency).
- Dwell counter increments each cycle unless hold=1.
- Leave to BLANK, clearing the dwell counter, on any of:
  - dwell counter reaches DWELL_CYCLES-1 with hold=0;
  - next_page=1;
  - page_valid[cur_page]=0.
- Simultaneous exit causes produce a single BLANK entry (one advance only).

BLANK
- word=0 for exactly BLANK_CYCLES cycles.
- On the last cycle: if pick(cur_page, exclusive) is found, cur_page <= index, state <= SHOW, page_switch pulses; otherwise state <= IDLE.
- If cur_page is the only valid page, it is re-selected.

ALERT
- An alert_req in any state enters ALERT next cycle: latch alert_word, pulse alert_ack, clear the alert counter.
- While in ALERT, word = latched alert word.
- A new alert_req during ALERT re-latches the word, pulses alert_ack and restarts the alert counter.
- After ALERT_CYCLES cycles, go to BLANK with cur_page unchanged, and with resume search in inclusive mode (cur_page is retried first).
- alert_req has priority over every other transition in the same cycle; a coincident next_page is dropped.
- hold has no effect in ALERT, BLANK or IDLE.

Other rules
- Counters are 32-bit, compared for equality, and never wrap in normal operation.
- page_valid changes during BLANK are honoured at the search instant only.
- Reset asserted mid-operation returns to IDLE immediately; word=0 asynchronously.

Decomposition:
- Package seg_sched_pkg:
  - state enumeration constants: IDLE=2'd0, SHOW=2'd1, BLANK=2'd2, ALERT=2'd3;
  - counter width constant CNT_W=32;
  - PAGE_IDX_W=3.
- Sub-module seg_rr_pick: combinational round-robin finder with inputs valid[NUM_PAGES], start[2:0], inclusive, and outputs found, idx[2:0]. Unit-testable on its own.

Test Plan:
Common setup: NUM_PAGES=4, SEG_UNITS=4, DWELL=8, BLANK=2, ALERT=5.

1. Reset, then page_valid=4'b0101 with page0=32'h11111111, page2=32'h22222222 -> cur_page 0, 0, 2, 2, 0, …; each page shown 8 cycles; word=0 for 2 cycles between pages; page_switch pulses once per entry.
2. Mid-SHOW of page0, pulse next_page at dwell count 3 -> BLANK next cycle, page2 shown after 2 blank cycles; pulse next_page on the same cycle as dwell expiry -> exactly one advance.
3. hold=1 for 20 cycles during page0 -> word stays 32'h11111111 for 28 cycles total; next_page during hold still advances.
4. alert_req with alert_word=32'hDEADBEEF during page2 SHOW -> alert_ack pulse next cycle; word=32'hDEADBEEF for 5 cycles; 2 blank cycles; page2 resumes with a fresh dwell. A second alert_req at alert cycle 3 -> second ack, 5 more cycles.
5. Clear page_valid[cur_page] mid-SHOW with no other page valid -> BLANK then IDLE, word=0; set page_valid=4'b1000 -> cur_page=3, SHOW.
6. Assert reset asynchronously during ALERT -> word=0, alert_ack=0, cur_page=0 without waiting for a clk edge; after release, IDLE behaviour as in scenario 1.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared constants for the segment-display page scheduler.
package seg_sched_pkg;

  // Scheduler states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;
  localparam logic [1:0] ALERT = 2'd3;

  // Width of the dwell / blank / alert counters
  localparam int CNT_W = 32;

  // Width of a page index (up to 8 pages)
  localparam int PAGE_IDX_W = 3;

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin finder: returns the first valid page at or
// after (inclusive) or strictly after (exclusive, start tested last) start.
module seg_rr_pick
  import seg_sched_pkg::*;
#(
  parameter int NUM_PAGES = 4
) (
  input  logic [NUM_PAGES-1:0]  valid,
  input  logic [PAGE_IDX_W-1:0] start,
  input  logic                  inclusive,
  output logic                  found,
  output logic [PAGE_IDX_W-1:0] idx
);

  localparam int NSLOT = 1 << PAGE_IDX_W;

  logic [NSLOT-1:0]      valid_ext;
  logic [PAGE_IDX_W-1:0] cand [NUM_PAGES];

  assign valid_ext = NSLOT'(valid);

  // Candidate k is start+k (inclusive) or start+k+1 (exclusive), wrapped.
  generate
    for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_cand
      assign cand[gi] = PAGE_IDX_W'((int'(start) + gi + (inclusive ? 0 : 1)) % NUM_PAGES);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_PAGES - 1; k >= 0; k--) begin
      if (valid_ext[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/seg_page_sched.sv
// Time-shares one raw 7-segment display between round-robin producer pages
// (with dwell and blank gap) and a pre-empting alert source.
module seg_page_sched
  import seg_sched_pkg::*;
#(
  parameter int          SEG_UNITS    = 4,
  parameter int          NUM_PAGES    = 4,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned BLANK_CYCLES = 5000000,
  parameter int unsigned ALERT_CYCLES = 100000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PAGES*SEG_UNITS*8-1:0] page_word,
  input  logic [NUM_PAGES-1:0]            page_valid,
  input  logic                            next_page,
  input  logic                            hold,
  input  logic                            alert_req,
  input  logic [SEG_UNITS*8-1:0]          alert_word,
  output logic                            alert_ack,
  output logic [SEG_UNITS*8-1:0]          word,
  output logic [PAGE_IDX_W-1:0]           cur_page,
  output logic                            page_switch
);

  localparam int W     = SEG_UNITS * 8;
  localparam int NSLOT = 1 << PAGE_IDX_W;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [W-1:0]          word_q, word_d;
  logic [PAGE_IDX_W-1:0] cur_page_q, cur_page_d;
  logic                  alert_ack_q, alert_ack_d;
  logic                  page_switch_q, page_switch_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;
  logic [CNT_W-1:0]      blank_q, blank_d;
  logic [CNT_W-1:0]      alert_cnt_q, alert_cnt_d;
  logic [W-1:0]          alert_word_q, alert_word_d;
  logic                  resume_incl_q, resume_incl_d;

  logic [W-1:0]          page_arr [NSLOT];
  logic [NSLOT-1:0]      valid_ext;
  logic [PAGE_IDX_W-1:0] pick_start;
  logic                  pick_incl;
  logic                  pick_found;
  logic [PAGE_IDX_W-1:0] pick_idx;
  logic                  show_exit;

  // Unused index slots read as blank so any 3-bit index is safe.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_page
      if (gi < NUM_PAGES) begin : g_real
        assign page_arr[gi] = page_word[gi*W +: W];
      end else begin : g_pad
        assign page_arr[gi] = '0;
      end
    end
  endgenerate

  assign valid_ext = NSLOT'(page_valid);

  // IDLE always searches from page 0 inclusively; BLANK searches from the
  // current page, inclusive only when resuming after an alert.
  assign pick_start = (state_q == IDLE) ? '0 : cur_page_q;
  assign pick_incl  = (state_q == IDLE) ? 1'b1 : resume_incl_q;

  seg_rr_pick #(
    .NUM_PAGES(NUM_PAGES)
  ) u_pick (
    .valid    (page_valid),
    .start    (pick_start),
    .inclusive(pick_incl),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // All exit causes collapse into one BLANK entry.
  assign show_exit = ((dwell_q == DWELL_LAST) && !hold) || next_page ||
                     !valid_ext[cur_page_q];

  // Next-state logic; alert_req overrides every other transition.
  always_comb begin
    state_d       = state_q;
    cur_page_d    = cur_page_q;
    dwell_d       = dwell_q;
    blank_d       = blank_q;
    alert_cnt_d   = alert_cnt_q;
    alert_word_d  = alert_word_q;
    resume_incl_d = resume_incl_q;
    alert_ack_d   = 1'b0;
    page_switch_d = 1'b0;
    if (alert_req) begin
      state_d      = ALERT;
      alert_word_d = alert_word;
      alert_ack_d  = 1'b1;
      alert_cnt_d  = '0;
      dwell_d      = '0;
      blank_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d       = SHOW;
            cur_page_d    = pick_idx;
            page_switch_d = 1'b1;
            dwell_d       = '0;
          end
        end
        SHOW: begin
          if (show_exit) begin
            state_d       = BLANK;
            dwell_d       = '0;
            blank_d       = '0;
            resume_incl_d = 1'b0;
          end else if (!hold) begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            blank_d       = '0;
            resume_incl_d = 1'b0;
            if (pick_found) begin
              state_d       = SHOW;
              cur_page_d    = pick_idx;
              page_switch_d = 1'b1;
              dwell_d       = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        ALERT: begin
          if (alert_cnt_q == ALERT_LAST) begin
            state_d       = BLANK;
            blank_d       = '0;
            alert_cnt_d   = '0;
            resume_incl_d = 1'b1;
          end else begin
            alert_cnt_d = alert_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output word follows the state being entered so it lines up with state_q.
  always_comb begin
    word_d = '0;
    case (state_d)
      SHOW:    word_d = page_arr[cur_page_d];
      ALERT:   word_d = alert_word_d;
      default: word_d = '0;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      word_q        <= '0;
      cur_page_q    <= '0;
      alert_ack_q   <= 1'b0;
      page_switch_q <= 1'b0;
      dwell_q       <= '0;
      blank_q       <= '0;
      alert_cnt_q   <= '0;
      alert_word_q  <= '0;
      resume_incl_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      cur_page_q    <= cur_page_d;
      alert_ack_q   <= alert_ack_d;
      page_switch_q <= page_switch_d;
      dwell_q       <= dwell_d;
      blank_q       <= blank_d;
      alert_cnt_q   <= alert_cnt_d;
      alert_word_q  <= alert_word_d;
      resume_incl_q <= resume_incl_d;
    end
  end

  assign word        = word_q;
  assign cur_page    = cur_page_q;
  assign alert_ack   = alert_ack_q;
  assign page_switch = page_switch_q;

endmodule

// File: tb/tb_seg_page_sched.sv
// Directed self-checking bench for seg_page_sched (DWELL=8, BLANK=2, ALERT=5).
module tb_seg_page_sched;

  localparam int NP = 4;
  localparam int W  = 32;

  localparam logic [W-1:0] P0 = 32'h11111111;
  localparam logic [W-1:0] P1 = 32'h44444444;
  localparam logic [W-1:0] P2 = 32'h22222222;
  localparam logic [W-1:0] P3 = 32'h33333333;

  logic            clk;
  logic            reset;
  logic [NP*W-1:0] page_word;
  logic [NP-1:0]   page_valid;
  logic            next_page;
  logic            hold;
  logic            alert_req;
  logic [W-1:0]    alert_word;
  logic            alert_ack;
  logic [W-1:0]    word;
  logic [2:0]      cur_page;
  logic            page_switch;

  int tests = 0;
  int fails = 0;

  seg_page_sched #(
    .SEG_UNITS(4), .NUM_PAGES(NP),
    .DWELL_CYCLES(8), .BLANK_CYCLES(2), .ALERT_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .page_word(page_word), .page_valid(page_valid),
    .next_page(next_page), .hold(hold), .alert_req(alert_req),
    .alert_word(alert_word), .alert_ack(alert_ack), .word(word),
    .cur_page(cur_page), .page_switch(page_switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; next_page = 1'b0; hold = 1'b0; alert_req = 1'b0;
    alert_word = '0; page_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; next_page = 1'b0; hold = 1'b0; alert_req = 1'b0;
    alert_word = '0; page_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (word !== '0) begin fails++; $display("FAIL reset_word got %h want 0", word); end
    tests++; if ({cur_page, alert_ack, page_switch} !== 5'b0) begin fails++;
      $display("FAIL reset_ctl got cur=%0d ack=%b sw=%b want 0/0/0", cur_page, alert_ack, page_switch); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({word, cur_page, page_switch} !== '0) begin fails++;
        $display("FAIL idle_empty cyc%0d got word=%h cur=%0d sw=%b want 0", i, word, cur_page, page_switch); end
    end
    $display("[TB] test_reset done");
  endtask

  // Pages 0 and 2: 8 show cycles, 2 blank cycles, alternating.
  task automatic test_rotation();
    logic [W-1:0] exp_w;
    logic [2:0]   exp_p;
    int pos;
    do_reset();
    page_valid = 4'b0101;
    for (int i = 1; i <= 30; i++) begin
      step();
      pos   = (i - 1) % 10;
      exp_p = (((i - 1) / 10) % 2 == 1) ? 3'd2 : 3'd0;
      exp_w = (pos < 8) ? ((exp_p == 3'd2) ? P2 : P0) : '0;
      tests++; if (word !== exp_w) begin fails++; $display("FAIL rot_word cyc%0d got %h want %h", i, word, exp_w); end
      tests++; if (cur_page !== exp_p) begin fails++; $display("FAIL rot_page cyc%0d got %0d want %0d", i, cur_page, exp_p); end
      tests++; if (page_switch !== (pos == 0)) begin fails++; $display("FAIL rot_switch cyc%0d got %b want %b", i, page_switch, pos == 0); end
    end
    $display("[TB] test_rotation done");
  endtask

  task automatic test_next_page();
    do_reset();
    page_valid = 4'b0101;
    repeat (4) step();                 // page0, dwell count 3
    next_page = 1'b1; step(); next_page = 1'b0;
    tests++; if (word !== '0) begin fails++; $display("FAIL np_blank got %h want 0", word); end
    step();
    step();
    tests++; if ({cur_page, word, page_switch} !== {3'd2, P2, 1'b1}) begin fails++;
      $display("FAIL np_page2 got cur=%0d word=%h sw=%b want 2/%h/1", cur_page, word, page_switch, P2); end
    repeat (7) step();                 // page2, dwell count 7
    tests++; if (word !== P2) begin fails++; $display("FAIL np_lastdwell got %h want %h", word, P2); end
    next_page = 1'b1; step(); next_page = 1'b0;
    tests++; if (word !== '0) begin fails++; $display("FAIL np_coinc_blank got %h want 0", word); end
    step();
    step();
    tests++; if ({cur_page, word, page_switch} !== {3'd0, P0, 1'b1}) begin fails++;
      $display("FAIL np_single_adv got cur=%0d word=%h sw=%b want 0/%h/1", cur_page, word, page_switch, P0); end
    repeat (7) step();
    tests++; if ({cur_page, word} !== {3'd0, P0}) begin fails++;
      $display("FAIL np_full_dwell got cur=%0d word=%h want 0/%h", cur_page, word, P0); end
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL np_after_dwell got %h want 0", word); end
    $display("[TB] test_next_page done");
  endtask

  task automatic test_hold();
    do_reset();
    page_valid = 4'b0101;
    step(); step();
    hold = 1'b1;
    for (int i = 3; i <= 28; i++) begin
      step();
      if (i == 22) hold = 1'b0;
      tests++; if (word !== P0) begin fails++; $display("FAIL hold_word cyc%0d got %h want %h", i, word, P0); end
    end
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL hold_end got %h want 0", word); end
    step(); step();
    tests++; if ({cur_page, word} !== {3'd2, P2}) begin fails++;
      $display("FAIL hold_page2 got cur=%0d word=%h want 2/%h", cur_page, word, P2); end
    step();
    hold = 1'b1; next_page = 1'b1; step(); next_page = 1'b0;
    tests++; if (word !== '0) begin fails++; $display("FAIL hold_np got %h want 0", word); end
    step(); step();
    tests++; if ({cur_page, word, page_switch} !== {3'd0, P0, 1'b1}) begin fails++;
      $display("FAIL hold_np_adv got cur=%0d word=%h sw=%b want 0/%h/1", cur_page, word, page_switch, P0); end
    hold = 1'b0;
    $display("[TB] test_hold done");
  endtask

  task automatic test_alert();
    do_reset();
    page_valid = 4'b0101;
    repeat (12) step();                // page2, dwell count 1
    tests++; if ({cur_page, word} !== {3'd2, P2}) begin fails++;
      $display("FAIL al_pre got cur=%0d word=%h want 2/%h", cur_page, word, P2); end
    alert_word = 32'hDEADBEEF; alert_req = 1'b1; step(); alert_req = 1'b0;
    alert_word = 32'h0BADF00D;
    tests++; if ({alert_ack, word} !== {1'b1, 32'hDEADBEEF}) begin fails++;
      $display("FAIL al_ack got ack=%b word=%h want 1/deadbeef", alert_ack, word); end
    for (int i = 14; i <= 17; i++) begin
      step();
      tests++; if ({alert_ack, word} !== {1'b0, 32'hDEADBEEF}) begin fails++;
        $display("FAIL al_hold cyc%0d got ack=%b word=%h want 0/deadbeef", i, alert_ack, word); end
    end
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL al_blank got %h want 0", word); end
    step(); step();
    tests++; if ({cur_page, word, page_switch} !== {3'd2, P2, 1'b1}) begin fails++;
      $display("FAIL al_resume got cur=%0d word=%h sw=%b want 2/%h/1", cur_page, word, page_switch, P2); end
    repeat (7) step();
    tests++; if (word !== P2) begin fails++; $display("FAIL al_fresh_dwell got %h want %h", word, P2); end
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL al_dwell_end got %h want 0", word); end
    alert_word = 32'hCAFEF00D; alert_req = 1'b1; step(); alert_req = 1'b0;
    tests++; if ({alert_ack, word} !== {1'b1, 32'hCAFEF00D}) begin fails++;
      $display("FAIL al2_ack got ack=%b word=%h want 1/cafef00d", alert_ack, word); end
    step(); step();
    tests++; if ({alert_ack, word} !== {1'b0, 32'hCAFEF00D}) begin fails++;
      $display("FAIL al2_mid got ack=%b word=%h want 0/cafef00d", alert_ack, word); end
    alert_word = 32'h12345678; alert_req = 1'b1; step(); alert_req = 1'b0;
    tests++; if ({alert_ack, word} !== {1'b1, 32'h12345678}) begin fails++;
      $display("FAIL al3_ack got ack=%b word=%h want 1/12345678", alert_ack, word); end
    for (int i = 33; i <= 36; i++) begin
      step();
      tests++; if (word !== 32'h12345678) begin fails++;
        $display("FAIL al3_hold cyc%0d got %h want 12345678", i, word); end
    end
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL al3_blank got %h want 0", word); end
    step(); step();
    tests++; if ({cur_page, word, page_switch} !== {3'd2, P2, 1'b1}) begin fails++;
      $display("FAIL al3_resume got cur=%0d word=%h sw=%b want 2/%h/1", cur_page, word, page_switch, P2); end
    $display("[TB] test_alert done");
  endtask

  task automatic test_invalidate();
    do_reset();
    page_valid = 4'b0001;
    repeat (3) step();
    page_valid = 4'b0000;
    step();
    tests++; if (word !== '0) begin fails++; $display("FAIL inv_blank got %h want 0", word); end
    step(); step(); step();
    tests++; if ({word, page_switch} !== '0) begin fails++;
      $display("FAIL inv_idle got word=%h sw=%b want 0/0", word, page_switch); end
    page_valid = 4'b1000;
    step();
    tests++; if ({cur_page, word, page_switch} !== {3'd3, P3, 1'b1}) begin fails++;
      $display("FAIL inv_page3 got cur=%0d word=%h sw=%b want 3/%h/1", cur_page, word, page_switch, P3); end
    step();
    tests++; if ({word, page_switch} !== {P3, 1'b0}) begin fails++;
      $display("FAIL inv_page3b got word=%h sw=%b want %h/0", word, page_switch, P3); end
    $display("[TB] test_invalidate done");
  endtask

  task automatic test_async_reset();
    do_reset();
    page_valid = 4'b0101;
    repeat (12) step();
    alert_word = 32'hA5A5A5A5; alert_req = 1'b1; step(); alert_req = 1'b0;
    tests++; if ({alert_ack, cur_page, word} !== {1'b1, 3'd2, 32'hA5A5A5A5}) begin fails++;
      $display("FAIL ar_pre got ack=%b cur=%0d word=%h want 1/2/a5a5a5a5", alert_ack, cur_page, word); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({word, alert_ack, cur_page, page_switch} !== '0) begin fails++;
      $display("FAIL ar_async got word=%h ack=%b cur=%0d sw=%b want 0", word, alert_ack, cur_page, page_switch); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    tests++; if ({cur_page, word, page_switch} !== {3'd0, P0, 1'b1}) begin fails++;
      $display("FAIL ar_restart got cur=%0d word=%h sw=%b want 0/%h/1", cur_page, word, page_switch, P0); end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    page_word = {P3, P2, P1, P0};
    test_reset();
    test_rotation();
    test_next_page();
    test_hold();
    test_alert();
    test_invalidate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
